// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a shifting 3x3 window,
// and one registered output slot hands each interior-pixel window downstream.
module sobel_window_gen #(
  parameter int DATA_W            = 8,
  parameter int IMAGE_ROW_SIZE    = 5,
  parameter int IMAGE_COLUMN_SIZE = 5,
  localparam int RW = $clog2(IMAGE_ROW_SIZE),
  localparam int CW = $clog2(IMAGE_COLUMN_SIZE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W-1:0]   pix_i,
  input  logic                pix_valid_i,
  output logic                pix_ready_o,
  output logic [9*DATA_W-1:0] win_o,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic [RW-1:0]       win_row_o,
  output logic [CW-1:0]       win_col_o,
  output logic                frame_done_o,
  output logic [1:0]          dbg_state_o
);

  // Handshakes (both ports): a transfer happens on a rising edge where valid && ready.
  // Valid is never withdrawn and its data never changes until the transfer occurs.
  typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t              r_state;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [DATA_W-1:0]   r_lb0 [IMAGE_COLUMN_SIZE];
  logic [DATA_W-1:0]   r_lb1 [IMAGE_COLUMN_SIZE];
  logic [9*DATA_W-1:0] r_win;
  logic [9*DATA_W-1:0] r_win_out;
  logic                r_win_valid;
  logic [RW-1:0]       r_win_row;
  logic [CW-1:0]       r_win_col;
  logic                r_done;

  logic                w_ready;
  logic                w_xfer;
  logic                w_out_hs;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_emit;
  logic [DATA_W-1:0]   w_col_in [3];
  logic [9*DATA_W-1:0] w_win_next;

  assign w_ready    = !rst_i && (r_state != S_DRAIN) && (!r_win_valid || win_ready_i);
  assign w_xfer     = pix_valid_i && w_ready;
  assign w_out_hs   = r_win_valid && win_ready_i;
  assign w_col_last = (r_col == CW'(IMAGE_COLUMN_SIZE - 1));
  assign w_row_last = (r_row == RW'(IMAGE_ROW_SIZE - 1));
  assign w_emit     = w_xfer && (r_row >= RW'(2)) && (r_col >= CW'(2));

  // New right-hand column is rows r-2, r-1, r at the current column.
  always_comb begin
    w_col_in[0] = r_lb0[r_col];
    w_col_in[1] = r_lb1[r_col];
    w_col_in[2] = pix_i;
    w_win_next  = '0;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        if (wc < 2)
          w_win_next[(3*wr+wc)*DATA_W +: DATA_W] = r_win[(3*wr+wc+1)*DATA_W +: DATA_W];
        else
          w_win_next[(3*wr+wc)*DATA_W +: DATA_W] = w_col_in[wr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_xfer) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pix_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_FILL;
      r_row       <= '0;
      r_col       <= '0;
      r_win       <= '0;
      r_win_out   <= '0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_out_hs)
        r_win_valid <= 1'b0;
      if (w_xfer) begin
        r_win <= w_win_next;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      // An emitting transfer overrides the clear above, keeping 1 window/cycle throughput.
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_out   <= w_win_next;
        r_win_row   <= r_row - RW'(1);
        r_win_col   <= r_col - CW'(1);
      end
      case (r_state)
        S_FILL:  if (w_xfer && (r_row == RW'(1)) && w_col_last) r_state <= S_RUN;
        S_RUN:   if (w_xfer && w_row_last && w_col_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_out_hs) begin
                   r_state <= S_FILL;
                   r_done  <= 1'b1;
                 end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign pix_ready_o  = w_ready;
  assign win_o        = r_win_out;
  assign win_valid_o  = r_win_valid;
  assign win_row_o    = r_win_row;
  assign win_col_o    = r_win_col;
  assign frame_done_o = r_done;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: directed ramp frames plus random traffic, checked every
// cycle against a frame-image model that derives windows from the accepted pixel stream.
module tb_sobel_window_gen;
  localparam int DW = 8;
  localparam int R  = 5;
  localparam int C  = 5;
  localparam int RW = $clog2(R);
  localparam int CW = $clog2(C);
  localparam int W  = RW + CW + 9*DW;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [DW-1:0]   pix_i;
  logic            pix_valid_i;
  logic            pix_ready_o;
  logic [9*DW-1:0] win_o;
  logic            win_valid_o;
  logic            win_ready_i;
  logic [RW-1:0]   win_row_o;
  logic [CW-1:0]   win_col_o;
  logic            frame_done_o;
  logic [1:0]      dbg_state_o;

  sobel_window_gen #(.DATA_W(DW), .IMAGE_ROW_SIZE(R), .IMAGE_COLUMN_SIZE(C)) dut (
    .clk_i(clk), .rst_i(rst_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .win_o(win_o), .win_valid_o(win_valid_o),
    .win_ready_i(win_ready_i), .win_row_o(win_row_o), .win_col_o(win_col_o),
    .frame_done_o(frame_done_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  bit mon_en   = 1'b0;
  bit tog      = 1'b0;
  int rdy_mode = 0;
  int stall_left = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_q[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: win_ready_i = 1'($urandom_range(0, 1));
        2: if (win_valid_o && stall_left > 0) begin
             win_ready_i = 1'b0;
             stall_left--;
           end else begin
             win_ready_i = 1'b1;
           end
        default: win_ready_i = 1'b1;
      endcase
    end
  end

  // ---------------- pixel driver tasks ----------------
  task automatic send_pixel(input logic [DW-1:0] p, input int vmode);
    int guard = 0;
    bit done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      pix_i = p;
      if (vmode == 0) pix_valid_i = 1'b1;
      else if (vmode == 1) begin
        pix_valid_i = tog;
        tog = !tog;
      end else pix_valid_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pix_valid_i && pix_ready_o) done = 1'b1;
      guard++;
      if (!done && guard > 300) begin
        chk("pixel_accept_timeout", 1'b0, 1'b1);
        done = 1'b1;
      end
    end
  endtask

  // base < 0 selects random pixel values
  task automatic send_frame(input int base, input int vmode, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (base < 0) send_pixel(DW'($urandom_range(0, 255)), vmode);
      else          send_pixel(DW'(base + i + 1), vmode);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_win_valid"}, win_valid_o, 1'b0);
    chk({tag, "_win_o"}, win_o, '0);
    chk({tag, "_win_row"}, win_row_o, '0);
    chk({tag, "_win_col"}, win_col_o, '0);
    chk({tag, "_frame_done"}, frame_done_o, 1'b0);
  endtask

  // ---------------- reference model + scoreboard ----------------
  int   img [R][C];
  int   m_r = 0, m_c = 0;
  logic m_valid = 1'b0, m_drain = 1'b0, m_done = 1'b0;

  always @(negedge clk) begin
    logic         exp_ready, xfer, hs, done_nx;
    logic [W-1:0] got;
    logic [9*DW-1:0] w;
    if (mon_en) begin
      exp_ready = !rst_i && !m_drain && (!m_valid || win_ready_i);
      got = {win_row_o, win_col_o, win_o};
      chk("pix_ready", pix_ready_o, exp_ready);
      chk("win_valid", win_valid_o, m_valid);
      chk("frame_done", frame_done_o, m_done);
      if (frame_done_o === 1'b1) n_done++;
      if (m_valid) begin
        if (exp_q.size() == 0) chk("window_unexpected", 1'b1, 1'b0);
        else                   chk("window", got, exp_q[0]);
      end
      if (rst_i) begin
        m_valid = 1'b0; m_drain = 1'b0; m_done = 1'b0;
        m_r = 0; m_c = 0;
        exp_q.delete();
      end else begin
        xfer    = pix_valid_i && exp_ready;
        hs      = m_valid && win_ready_i;
        done_nx = hs && m_drain;
        if (hs) begin
          acc_q.push_back(got);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_valid = 1'b0;
          m_drain = 1'b0;
        end
        if (xfer) begin
          img[m_r][m_c] = int'(pix_i);
          if (m_r >= 2 && m_c >= 2) begin
            for (int wr = 0; wr < 3; wr++)
              for (int wc = 0; wc < 3; wc++)
                w[(3*wr+wc)*DW +: DW] = DW'(img[m_r-2+wr][m_c-2+wc]);
            exp_q.push_back({RW'(m_r-1), CW'(m_c-1), w});
            m_valid = 1'b1;
          end
          if (m_r == R-1 && m_c == C-1) m_drain = 1'b1;
          if (m_c == C-1) begin
            m_c = 0;
            m_r = (m_r == R-1) ? 0 : m_r + 1;
          end else m_c = m_c + 1;
        end
        m_done = done_nx;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_i = 1'b1; pix_valid_i = 1'b0; pix_i = '0; win_ready_i = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    chk("reset_pix_ready", pix_ready_o, 1'b1);

    // plain ramp, full throughput
    send_frame(0, 0, R*C); idle(12);
    chk("t1_count", acc_q.size(), 9);
    chk("t1_first", acc_q[0], {3'd1, 3'd1, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13)});
    chk("t1_last",  acc_q[8], {3'd3, 3'd3, pack9(13, 14, 15, 18, 19, 20, 23, 24, 25)});
    chk("t1_done",  n_done, 1);

    // downstream stall of 4 cycles on the first window
    stall_left = 4; rdy_mode = 2;
    send_frame(0, 0, R*C); idle(12);
    rdy_mode = 0;
    chk("t2_count", acc_q.size(), 18);
    chk("t2_first", acc_q[9], {3'd1, 3'd1, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13)});

    // input bubbles every other cycle
    tog = 1'b1;
    send_frame(0, 1, R*C); idle(12);
    chk("t3_count", acc_q.size(), 27);
    chk("t3_mid", acc_q[22], {3'd2, 3'd2, pack9(7, 8, 9, 12, 13, 14, 17, 18, 19)});

    // back-to-back frames
    send_frame(0, 0, R*C); send_frame(100, 0, R*C); idle(12);
    chk("t4_count", acc_q.size(), 45);
    chk("t4_f2_first", acc_q[36], {3'd1, 3'd1, pack9(101, 102, 103, 106, 107, 108, 111, 112, 113)});
    chk("t4_done", n_done, 5);

    // reset after 12 accepted pixels, then a clean frame
    send_frame(0, 0, 12);
    @(posedge clk); #1;
    rst_i = 1'b1; pix_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    send_frame(0, 0, R*C); idle(12);
    chk("t5_count", acc_q.size(), 54);
    chk("t5_first", acc_q[45], {3'd1, 3'd1, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13)});
    chk("t5_done", n_done, 6);

    // random traffic over 20 frames
    rdy_mode = 1;
    repeat (20) send_frame(-1, 2, R*C);
    rdy_mode = 0;
    idle(30);
    chk("t6_count", acc_q.size(), 9*26);
    chk("t6_done", n_done, 26);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
